inst_fetch_stage: RTL and testbench

//  MIPS32 instruction-fetch stage: owns the PC and issues requests on the sram-like instruction bus.

---
 rtl/inst_fetch_stage.sv | 150 +++++++++++++++
 tb/tb_inst_fetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, drives the sram-like instruction bus with at most
// one outstanding request, and hands inst/pc to decode over a valid/allowin handshake.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_flush,
    input  logic [31:0] exc_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_inst,
    output logic [31:0] fs_pc,
    output logic        fs_adel
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

    state_t      state, state_nxt;
    logic [31:0] seq_pc, seq_pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic [31:0] br_tgt, br_tgt_nxt;
    logic        br_pend, br_pend_nxt;
    logic        cancel, cancel_nxt;
    logic        req_en;
    logic [31:0] buf_inst, buf_inst_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic        buf_adel, buf_adel_nxt;
    logic        pc_misaligned;
    logic        req_fire;

    // req_en keeps the bus quiet for the first cycle after reset
    assign pc_misaligned  = (seq_pc[1:0] != 2'b00);
    assign inst_req       = req_en && (state == S_REQ) && !pc_misaligned;
    assign inst_addr      = seq_pc;
    assign req_fire       = inst_req && inst_addr_ok;
    assign fs_to_ds_valid = (state == S_FULL);
    assign fs_inst        = buf_inst;
    assign fs_pc          = buf_pc;
    assign fs_adel        = buf_adel;

    always_comb begin
        state_nxt    = state;
        seq_pc_nxt   = seq_pc;
        req_pc_nxt   = req_pc;
        br_tgt_nxt   = br_tgt;
        br_pend_nxt  = br_pend;
        cancel_nxt   = cancel;
        buf_inst_nxt = buf_inst;
        buf_pc_nxt   = buf_pc;
        buf_adel_nxt = buf_adel;

        if (exc_flush) begin
            // A request already on the bus must still drain; its data is dropped via cancel
            seq_pc_nxt  = exc_target;
            br_pend_nxt = 1'b0;
            if (req_fire || (state == S_WAIT && !inst_data_ok)) begin
                state_nxt  = S_WAIT;
                cancel_nxt = 1'b1;
            end else begin
                state_nxt  = S_REQ;
                cancel_nxt = 1'b0;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (req_en && pc_misaligned) begin
                        buf_inst_nxt = 32'h0;
                        buf_pc_nxt   = seq_pc;
                        buf_adel_nxt = 1'b1;
                        state_nxt    = S_FULL;
                    end else if (req_fire) begin
                        req_pc_nxt  = seq_pc;
                        br_pend_nxt = 1'b0;
                        state_nxt   = S_WAIT;
                        if (br_taken)
                            seq_pc_nxt = br_target;
                        else if (br_pend)
                            seq_pc_nxt = br_tgt;
                        else
                            seq_pc_nxt = seq_pc + 32'd4;
                    end
                    // Delay slot not yet accepted: redirect the request after it
                    if (br_taken && !req_fire) begin
                        br_pend_nxt = 1'b1;
                        br_tgt_nxt  = br_target;
                    end
                end
                S_WAIT: begin
                    if (br_taken && !cancel)
                        seq_pc_nxt = br_target;
                    if (inst_data_ok) begin
                        if (cancel) begin
                            cancel_nxt = 1'b0;
                            state_nxt  = S_REQ;
                        end else begin
                            buf_inst_nxt = inst_rdata;
                            buf_pc_nxt   = req_pc;
                            buf_adel_nxt = 1'b0;
                            state_nxt    = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (br_taken)
                        seq_pc_nxt = br_target;
                    if (id_allowin)
                        state_nxt = S_REQ;
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_REQ;
            seq_pc   <= RESET_PC;
            br_pend  <= 1'b0;
            cancel   <= 1'b0;
            req_en   <= 1'b0;
            buf_inst <= 32'h0;
            buf_pc   <= 32'h0;
            buf_adel <= 1'b0;
        end else begin
            state    <= state_nxt;
            seq_pc   <= seq_pc_nxt;
            br_pend  <= br_pend_nxt;
            cancel   <= cancel_nxt;
            req_en   <= 1'b1;
            buf_inst <= buf_inst_nxt;
            buf_pc   <= buf_pc_nxt;
            buf_adel <= buf_adel_nxt;
        end
    end

    // Address holding registers: only meaningful once written by a handshake/branch
    always_ff @(posedge clk) begin
        req_pc <= req_pc_nxt;
        br_tgt <= br_tgt_nxt;
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Randomized bench for inst_fetch_stage: memory slave, decode consumer and a program-order
// reference model of which pc/instruction must be delivered next.
module tb_inst_fetch_stage;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam int          IDLE_LIMIT = 400;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_to_ds_valid;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
    logic        fs_adel;

    always #5 clk = ~clk;

    inst_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .id_allowin    (id_allowin),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .exc_flush     (exc_flush),
        .exc_target    (exc_target),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .fs_to_ds_valid(fs_to_ds_valid),
        .fs_inst       (fs_inst),
        .fs_pc         (fs_pc),
        .fs_adel       (fs_adel)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h3C5A, ~a[31:16]};
    endfunction

    function automatic logic [31:0] pick_target(input bit allow_mis);
        int sel;
        sel = $urandom_range(9);
        if (sel == 0) return 32'hFFFF_FFF8;
        if (allow_mis && sel == 1) return 32'hBFC0_0102;
        return RESET_PC + {22'd0, 8'($urandom_range(255)), 2'b00};
    endfunction

    // program-order model
    logic [31:0] exp_pc, pend_tgt, sched_tgt;
    bit          pend, br_sched, flush_sched, last_branch;
    // memory slave
    bit          busy;
    logic [31:0] baddr;
    int          cnt;
    // previous-cycle observations
    bit          prev_v, prev_allow, prev_flush, prev_req, prev_aok, prev_dok;
    logic [31:0] prev_pc, prev_inst, prev_addr;
    int          idle;
    int          allow_pct = 70;
    int          flush_pct = 3;
    bit          hung = 0;

    task automatic clear_model();
        exp_pc = RESET_PC; pend = 0; br_sched = 0; flush_sched = 0; last_branch = 0;
        busy = 0; cnt = 0; idle = 0;
        prev_v = 0; prev_allow = 0; prev_flush = 0; prev_req = 0; prev_aok = 0; prev_dok = 0;
        prev_pc = 0; prev_inst = 0; prev_addr = 0;
    endtask

    // Called at a falling edge: observe, check, drive this cycle's inputs, predict the next edge.
    task automatic step();
        logic        req, v, ad;
        logic [31:0] addr, inst, pc;
        bit          is_slot;
        req = inst_req; addr = inst_addr; v = fs_to_ds_valid;
        inst = fs_inst; pc = fs_pc; ad = fs_adel;

        if (req) check("req_aligned", {30'd0, addr[1:0]}, 32'd0);
        if (v) check("no_req_while_full", {31'd0, req}, 32'd0);
        if (prev_v && !prev_allow && !prev_flush) begin
            check("stall_valid", {31'd0, v}, 32'd1);
            check("stall_pc", pc, prev_pc);
            check("stall_inst", inst, prev_inst);
        end
        if (prev_req && !prev_aok && !prev_flush) begin
            check("req_held", {31'd0, req}, 32'd1);
            check("req_addr_held", addr, prev_addr);
        end
        if (v && !prev_v && !ad) check("data_to_valid_latency", {31'd0, prev_dok}, 32'd1);

        inst_addr_ok = req && !busy && ($urandom_range(9) < 6);
        inst_data_ok = busy && (cnt == 0);
        inst_rdata   = inst_data_ok ? mem_word(baddr) : $urandom;
        id_allowin   = ($urandom_range(99) < allow_pct);
        br_taken     = br_sched;
        br_target    = br_sched ? sched_tgt : $urandom;
        exc_flush    = flush_sched || ($urandom_range(99) < flush_pct);
        exc_target   = exc_flush ? pick_target(1'b0) : $urandom;

        br_sched = 0;
        idle++;
        if (exc_flush) begin
            exp_pc = exc_target; pend = 0; last_branch = 0; flush_sched = 0;
        end else begin
            if (br_taken) begin pend = 1; pend_tgt = br_target; end
            if (v && id_allowin) begin
                check("fs_pc", pc, exp_pc);
                check("fs_adel", {31'd0, exp_pc[1:0] != 2'b00}, {31'd0, ad});
                check("fs_inst", inst, (exp_pc[1:0] != 2'b00) ? 32'h0 : mem_word(exp_pc));
                idle = 0;
                is_slot = last_branch;
                last_branch = 0;
                exp_pc = pend ? pend_tgt : exp_pc + 32'd4;
                pend = 0;
                if (ad) flush_sched = 1;
                else if (!is_slot && $urandom_range(99) < 25) begin
                    br_sched = 1; sched_tgt = pick_target(1'b1); last_branch = 1;
                end
            end
        end

        if (inst_data_ok) busy = 0;
        else if (busy) cnt--;
        if (inst_addr_ok) begin busy = 1; baddr = addr; cnt = $urandom_range(3); end

        prev_v = v; prev_allow = id_allowin; prev_flush = exc_flush; prev_pc = pc; prev_inst = inst;
        prev_req = req; prev_aok = inst_addr_ok; prev_dok = inst_data_ok; prev_addr = addr;

        if (idle > IDLE_LIMIT) begin
            check("delivery_within_bound", idle, 32'd0);
            hung = 1;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n && !hung; i++) step();
    endtask

    task automatic do_reset(input bit stale);
        resetn = 1'b0; id_allowin = 0; br_taken = 0; exc_flush = 0;
        inst_addr_ok = 0; inst_data_ok = 0; br_target = 0; exc_target = 0; inst_rdata = 0;
        @(negedge clk);
        check("rst_inst_req", {31'd0, inst_req}, 32'd0);
        check("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
        check("rst_fs_inst", fs_inst, 32'd0);
        check("rst_fs_pc", fs_pc, 32'd0);
        check("rst_fs_adel", {31'd0, fs_adel}, 32'd0);
        check("rst_inst_addr", inst_addr, RESET_PC);
        resetn = 1'b1;
        clear_model();
        if (stale) begin inst_data_ok = 1; inst_rdata = 32'hDEAD_BEEF; end
        @(negedge clk);
        inst_data_ok = 0;
        check("req_after_reset", {31'd0, inst_req}, 32'd1);
        check("addr_after_reset", inst_addr, RESET_PC);
    endtask

    initial begin
        do_reset(1'b0);
        run(1500);
        allow_pct = 20;
        run(600);
        allow_pct = 70;
        for (int i = 0; i < 100 && !busy && !hung; i++) step();
        check("reached_wait_before_reset", {31'd0, busy}, 32'd1);
        do_reset(1'b1);
        run(1200);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
